// File: rtl/matmul_pkg.sv
// matmul_pkg: shared state encoding and sizing helpers for the matmul sequencer
package matmul_pkg;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, OUT, DONE} state_t;
  localparam int DEF_DATA_W = 20;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int res_w(input int dw, input int inner);
    return 2 * dw + $clog2(inner + 1);
  endfunction
endpackage

// File: rtl/matmul_sequencer_mac.sv
// mac_unit: unsigned multiply-accumulate; clear has priority over accumulate
module mac_unit #(
  parameter int DATA_W = 20,
  parameter int RES_W = 42
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [RES_W-1:0]  acc
);
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc + {{(RES_W-2*DATA_W){1'b0}}, prod};
endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks (i, j, k) over two sync-read memories through one MAC
// and streams C[i][j] out in row-major order over valid/ready.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int A_ROW = 5,
  parameter int A_COL = 3,
  parameter int B_COL = 6,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RES_W = res_w(DATA_W, A_COL)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  output logic                             busy,
  output logic                             done,
  output logic                             rd_en,
  output logic [addr_w(A_ROW*A_COL)-1:0]   a_addr,
  output logic [addr_w(A_COL*B_COL)-1:0]   b_addr,
  input  logic [DATA_W-1:0]                a_data,
  input  logic [DATA_W-1:0]                b_data,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [addr_w(A_ROW)-1:0]         res_row,
  output logic [addr_w(B_COL)-1:0]         res_col,
  output logic [RES_W-1:0]                 res_data
);
  localparam int I_W = addr_w(A_ROW);
  localparam int J_W = addr_w(B_COL);
  localparam int K_W = addr_w(A_COL);
  localparam int AA_W = addr_w(A_ROW*A_COL);
  localparam int BA_W = addr_w(A_COL*B_COL);
  state_t st, nxt;
  logic [I_W-1:0] i;
  logic [J_W-1:0] j;
  logic [K_W-1:0] k;
  logic rd_vld, last_k, last_j, last_ij, hs, clr;
  assign last_k = k == K_W'(A_COL - 1);
  assign last_j = j == J_W'(B_COL - 1);
  assign last_ij = last_j && i == I_W'(A_ROW - 1);
  assign hs = st == OUT && res_ready && !abort;
  assign clr = (st == IDLE && start) || hs;
  assign busy = st inside {RUN, DRAIN, OUT};
  assign done = st == DONE;
  assign rd_en = st == RUN;
  assign res_valid = st == OUT;
  assign res_row = i;
  assign res_col = j;
  assign a_addr = AA_W'(32'(i) * A_COL + 32'(k));
  assign b_addr = BA_W'(32'(k) * B_COL + 32'(j));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = start ? RUN : IDLE;
      RUN:     nxt = abort ? IDLE : last_k ? DRAIN : RUN;
      DRAIN:   nxt = abort ? IDLE : OUT;
      OUT:     nxt = abort ? IDLE : !res_ready ? OUT : last_ij ? DONE : RUN;
      default: nxt = IDLE;
    endcase
  end
  // rd_vld marks the cycle the memories return the word requested last cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      i <= '0;
      j <= '0;
      k <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= rd_en;
      if (st == IDLE && start) begin
        i <= '0;
        j <= '0;
        k <= '0;
      end else if (st == RUN) k <= last_k ? '0 : k + K_W'(1);
      else if (hs) begin
        k <= '0;
        j <= last_j ? '0 : j + J_W'(1);
        if (last_j) i <= last_ij ? '0 : i + I_W'(1);
      end
    end
  mac_unit #(.DATA_W(DATA_W), .RES_W(RES_W)) u_mac (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(rd_vld),
    .a(a_data), .b(b_data), .acc(res_data)
  );
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed and random jobs checked against a bench-side matrix product model
module tb_matmul_sequencer;
  localparam int AR = 5, AC = 3, BC = 6, DW = 20, RW = 42;
  typedef struct { int r; int c; logic [63:0] v; } exp_t;
  logic clk = 0, rst_n, start = 0, abort = 0, res_ready = 0;
  logic busy, done, rd_en, res_valid;
  logic [3:0] a_addr;
  logic [4:0] b_addr;
  logic [DW-1:0] a_data = 0, b_data = 0;
  logic [2:0] res_row, res_col;
  logic [RW-1:0] res_data;
  logic [DW-1:0] am [16];
  logic [DW-1:0] bm [32];
  logic start1 = 0, abort1 = 0, ready1 = 1;
  logic busy1, done1, rd1, valid1;
  logic [0:0] a_addr1, row1;
  logic [1:0] b_addr1, col1;
  logic [7:0] a1d = 0, b1d = 0;
  logic [16:0] data1;
  logic [7:0] am1 [2];
  logic [7:0] bm1 [4];
  exp_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0, acc_cnt = 0, done_cnt = 0, idx1 = 0;
  logic [63:0] first_data = 0;

  matmul_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr), .a_data(a_data), .b_data(b_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row), .res_col(res_col),
    .res_data(res_data)
  );
  matmul_sequencer #(.A_ROW(2), .A_COL(1), .B_COL(3), .DATA_W(8)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .busy(busy1), .done(done1),
    .rd_en(rd1), .a_addr(a_addr1), .b_addr(b_addr1), .a_data(a1d), .b_data(b1d),
    .res_valid(valid1), .res_ready(ready1), .res_row(row1), .res_col(col1),
    .res_data(data1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en) begin a_data <= am[a_addr]; b_data <= bm[b_addr]; end
  always @(posedge clk) if (rd1) begin a1d <= am1[a_addr1]; b1d <= bm1[b_addr1]; end
  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  always @(negedge clk) if (rst_n && res_valid) begin
    chk("rd_en_in_out", rd_en, 0);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL extra_result: got row %0d col %0d expected no result", res_row, res_col);
    end else begin
      chk("res_row", res_row, exp_q[0].r);
      chk("res_col", res_col, exp_q[0].c);
      chk("res_data", res_data, exp_q[0].v);
      if (res_ready && !abort) begin
        void'(exp_q.pop_front());
        acc_cnt++;
        if (acc_cnt == 1) first_data = res_data;
      end
    end
  end

  always @(negedge clk) if (rst_n && valid1) begin
    chk("u1_rd_en_in_out", rd1, 0);
    chk("u1_row", row1, idx1 / 3);
    chk("u1_col", col1, idx1 % 3);
    chk("u1_data", data1, 64'(am1[idx1/3]) * 64'(bm1[idx1%3]));
    idx1++;
  end

  task automatic fill(input bit max);
    for (int n = 0; n < 16; n++) am[n] = max ? '1 : DW'($urandom);
    for (int n = 0; n < 32; n++) bm[n] = max ? '1 : DW'($urandom);
  endtask

  task automatic build_exp();
    exp_t e;
    exp_q.delete();
    for (int r = 0; r < AR; r++)
      for (int c = 0; c < BC; c++) begin
        e.r = r;
        e.c = c;
        e.v = 0;
        for (int m = 0; m < AC; m++) e.v += 64'(am[r*AC+m]) * 64'(bm[m*BC+c]);
        exp_q.push_back(e);
      end
  endtask

  task automatic run_job(input int pct, input bit pulses, output int lat);
    int t0;
    build_exp();
    acc_cnt = 0;
    lat = -1;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    t0 = cyc;
    for (int n = 0; n < 3000; n++) begin
      if (done) begin lat = cyc - t0; break; end
      res_ready = $urandom_range(99) < pct;
      if (pulses) start = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    start = 0;
    res_ready = 1;
    chk("results_accepted", acc_cnt, 30);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, d, t0;
    bit ok;
    rst_n = 1;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_addrs_idx", {a_addr, b_addr, res_row, res_col}, 0);
    chk("rst_res_data", res_data, 0);
    @(negedge clk) rst_n = 1;

    fill(0);
    am[0] = 1000; am[1] = 2000; am[2] = 3000;
    bm[0] = 111111; bm[6] = 777777; bm[12] = 131313;
    run_job(100, 0, lat);
    chk("default_done_latency", lat, 150);
    chk("default_first_result", first_data, 64'd2060604000);

    fill(1);
    run_job(100, 0, lat);
    chk("max_done_latency", lat, 150);
    chk("max_first_result", first_data, 64'd3298528591875);

    fill(0);
    d = done_cnt;
    run_job(50, 1, lat);
    chk("bp_done_seen", lat >= 150, 1);
    chk("bp_single_done", done_cnt - d, 1);

    fill(0);
    build_exp();
    acc_cnt = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      if (acc_cnt == 2) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("abort_reached_2", ok, 1);
    chk("abort_in_run", {busy, rd_en}, 2'b11);
    d = done_cnt;
    abort = 1;
    @(posedge clk); #1 abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", rd_en, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, d);
    chk("abort_stays_idle", busy, 0);
    run_job(100, 0, lat);
    chk("after_abort_latency", lat, 150);

    fill(0);
    build_exp();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("drain_state", {busy, rd_en, res_valid}, 3'b100);
    rst_n = 0;
    #1;
    chk("midrst_ctrl", {busy, done, rd_en, res_valid}, 0);
    chk("midrst_idx", {a_addr, b_addr, res_row, res_col}, 0);
    chk("midrst_res_data", res_data, 0);
    exp_q.delete();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("midrst_idle", busy, 0);
    run_job(100, 0, lat);
    chk("after_reset_latency", lat, 150);

    for (int n = 0; n < 2; n++) am1[n] = 8'($urandom);
    for (int n = 0; n < 4; n++) bm1[n] = 8'($urandom);
    bm1[2] = 8'hff;
    am1[1] = 8'hff;
    idx1 = 0;
    lat = -1;
    @(posedge clk); #1 start1 = 1;
    @(posedge clk); #1 start1 = 0;
    t0 = cyc;
    for (int n = 0; n < 200; n++) begin
      if (done1) begin lat = cyc - t0; break; end
      @(posedge clk); #1;
    end
    chk("acol1_latency", lat, 18);
    chk("acol1_results", idx1, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
